// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one i2c master between N_REQ requesters
module i2c_req_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ-1:0]   req_wr_i,
    input  logic [7*N_REQ-1:0] req_addr_i,
    input  logic [8*N_REQ-1:0] req_wdata_i,
    output logic [N_REQ-1:0]   gnt_o,
    output logic [N_REQ-1:0]   rsp_done_o,
    output logic               rsp_err_o,
    output logic [7:0]         rsp_rdata_o,
    output logic               m_newd_o,
    output logic               m_wr_o,
    output logic [6:0]         m_addr_o,
    output logic [7:0]         m_wdata_o,
    input  logic [7:0]         m_rdata_i,
    input  logic               m_done_i
);
    localparam int IW  = $clog2(N_REQ);
    localparam int IW1 = IW + 1;
    localparam int TW  = $clog2(TIMEOUT_CYC);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]         state_q;
    logic [N_REQ-1:0]   gnt_q, rsp_done_q;
    logic [IW-1:0]      rr_q, win_q, win_d;
    logic [TW-1:0]      timer_q;
    logic               done_q, rsp_err_q, m_newd_q, m_wr_q, wr_d;
    logic [7:0]         rsp_rdata_q, m_wdata_q, wdata_d;
    logic [6:0]         m_addr_q, addr_d;
    logic [2*N_REQ-1:0] rot;
    logic [IW:0]        off, sum;

    // Winner is the first requester at or after rr_q; its fields are muxed out for latching
    always_comb begin
        rot = {req_i, req_i} >> rr_q;
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) off = rot[i] ? IW1'(i) : off;
        sum = {1'b0, rr_q} + off;
        win_d = (sum >= IW1'(N_REQ)) ? IW'(sum - IW1'(N_REQ)) : sum[IW-1:0];
        wr_d = 1'b0;
        addr_d = '0;
        wdata_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            wr_d = (win_d == IW'(i)) ? req_wr_i[i] : wr_d;
            addr_d = (win_d == IW'(i)) ? req_addr_i[7*i +: 7] : addr_d;
            wdata_d = (win_d == IW'(i)) ? req_wdata_i[8*i +: 8] : wdata_d;
        end
    end

    // Transaction sequencer: grant, launch pulse, wait for a fresh m_done edge or timeout, respond
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            rsp_done_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            m_newd_q    <= 1'b0;
            m_wr_q      <= 1'b1;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            rr_q        <= '0;
            win_q       <= '0;
            timer_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= m_done_i;
            m_newd_q   <= (state_q == S_LAUNCH);
            rsp_done_q <= '0;
            if (state_q == S_IDLE) begin
                if (|req_i) begin
                    gnt_q     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_d;
                    win_q     <= win_d;
                    m_wr_q    <= wr_d;
                    m_addr_q  <= addr_d;
                    m_wdata_q <= wdata_d;
                    state_q   <= S_LAUNCH;
                end
            end else if (state_q == S_LAUNCH) begin
                timer_q <= '0;
                state_q <= S_WAIT;
            end else if (state_q == S_WAIT) begin
                if (m_done_i && !done_q) begin
                    if (!m_wr_q) rsp_rdata_q <= m_rdata_i;
                    rsp_err_q  <= 1'b0;
                    rsp_done_q <= gnt_q;
                    state_q    <= S_RESP;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    rsp_err_q  <= 1'b1;
                    rsp_done_q <= gnt_q;
                    state_q    <= S_RESP;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end else begin
                gnt_q     <= '0;
                rsp_err_q <= 1'b0;
                rr_q      <= (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                state_q   <= S_IDLE;
            end
        end
    end

    assign gnt_o       = gnt_q;
    assign rsp_done_o  = rsp_done_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign m_newd_o    = m_newd_q;
    assign m_wr_o      = m_wr_q;
    assign m_addr_o    = m_addr_q;
    assign m_wdata_o   = m_wdata_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: randomized self-checking bench against a round-robin service model
module tb_i2c_req_arbiter;
    localparam int N = 4;
    localparam int T = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [N-1:0]   req, req_wr, gnt, rsp_done;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_wdata;
    logic           rsp_err, m_newd, m_wr, m_done;
    logic [7:0]     rsp_rdata, m_wdata, m_rdata;
    logic [6:0]     m_addr;

    i2c_req_arbiter #(.N_REQ(N), .TIMEOUT_CYC(T)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_wr_i(req_wr),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .gnt_o(gnt),
        .rsp_done_o(rsp_done), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
        .m_newd_o(m_newd), .m_wr_o(m_wr), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_rdata_i(m_rdata), .m_done_i(m_done)
    );

    int n_cmp = 0, n_bad = 0;
    int rr_m = 0;
    logic [7:0] rdata_m = 8'h00;
    int viol = 0, newd_cnt = 0;
    logic prev_newd = 1'b0;

    logic           srv_ok, cap_w, cap_w2, cap_e;
    logic [N-1:0]   cap_g, cap_d, cap_d2;
    logic [6:0]     cap_a, cap_a2;
    logic [7:0]     cap_wd, cap_rd;
    int             lat;

    // Structural invariants sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if ($countones(gnt) > 1 || $countones(rsp_done) > 1) viol++;
        if (rsp_err && rsp_done == '0) viol++;
        if (rsp_done != '0 && rsp_done != gnt) viol++;
        if (m_newd && prev_newd) viol++;
        if (m_newd) newd_cnt++;
        prev_newd = m_newd;
    end

    function automatic int pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) if (r[(rr_m + i) % N]) return (rr_m + i) % N;
        return -1;
    endfunction

    task automatic set_fields(input int i, input logic w, input logic [6:0] a, input logic [7:0] d);
        req_wr[i] = w;
        req_addr[7*i +: 7] = a;
        req_wdata[8*i +: 8] = d;
    endtask

    // Acts as the i2c master for one transaction and records what the arbiter presented
    task automatic serve(input bit nw, input int dly, input logic [7:0] rd, input bit respond, input bit scramble);
        srv_ok = 1'b1;
        if (nw) begin
            for (int i = 0; i < 40 && m_newd !== 1'b1; i++) @(negedge clk);
            srv_ok = (m_newd === 1'b1);
        end
        cap_g = gnt; cap_w = m_wr; cap_a = m_addr; cap_wd = m_wdata;
        if (scramble)
            for (int i = 0; i < N; i++)
                if (cap_g[i]) begin
                    req[i] = 1'b0;
                    set_fields(i, ~req_wr[i], 7'($urandom), 8'($urandom));
                end
        repeat (dly) @(negedge clk);
        if (respond) begin m_rdata = rd; m_done = 1'b1; end
        lat = 0;
        while (rsp_done == '0 && lat < 60) begin @(negedge clk); lat++; end
        cap_d = rsp_done; cap_e = rsp_err; cap_rd = rsp_rdata; cap_a2 = m_addr; cap_w2 = m_wr;
        @(negedge clk);
        cap_d2 = rsp_done;
        m_done = 1'b0;
        m_rdata = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; m_done = 1'b0; m_rdata = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (gnt !== '0 || rsp_done !== '0) begin n_bad++; $display("FAIL reset_gnt: gnt=%b done=%b want 0", gnt, rsp_done); end
        n_cmp++; if (rsp_err !== 1'b0 || m_newd !== 1'b0) begin n_bad++; $display("FAIL reset_flags: err=%b newd=%b want 0", rsp_err, m_newd); end
        n_cmp++; if ({m_wr, m_addr, m_wdata, rsp_rdata} !== {1'b1, 23'h0}) begin n_bad++; $display("FAIL reset_data: wr=%b addr=%h wdata=%h rdata=%h want 1/0/0/0", m_wr, m_addr, m_wdata, rsp_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        rr_m = 0; rdata_m = 8'h00;
    endtask

    task automatic test_write();
        int n0;
        set_fields(2, 1'b1, 7'h55, 8'hA5);
        n0 = newd_cnt;
        req = 4'b0100;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0100 || m_newd !== 1'b0) begin n_bad++; $display("FAIL wr_grant: gnt=%b newd=%b want 0100/0", gnt, m_newd); end
        @(negedge clk);
        n_cmp++; if (m_newd !== 1'b1) begin n_bad++; $display("FAIL wr_newd_lat: newd=%b want 1", m_newd); end
        serve(1'b0, 3, 8'hEE, 1'b1, 1'b0);
        req = '0;
        n_cmp++; if ({cap_w, cap_a, cap_wd} !== {1'b1, 7'h55, 8'hA5}) begin n_bad++; $display("FAIL wr_fields: wr=%b addr=%h wdata=%h want 1/55/a5", cap_w, cap_a, cap_wd); end
        n_cmp++; if (cap_d !== 4'b0100 || cap_e !== 1'b0 || lat != 1) begin n_bad++; $display("FAIL wr_done: done=%b err=%b lat=%0d want 0100/0/1", cap_d, cap_e, lat); end
        n_cmp++; if (cap_d2 !== '0) begin n_bad++; $display("FAIL wr_done_width: done=%b want 0", cap_d2); end
        n_cmp++; if (cap_rd !== rdata_m) begin n_bad++; $display("FAIL wr_rdata_kept: rdata=%h want %h", cap_rd, rdata_m); end
        n_cmp++; if (newd_cnt - n0 != 1) begin n_bad++; $display("FAIL wr_newd_count: %0d want 1", newd_cnt - n0); end
        rr_m = 3;
    endtask

    task automatic test_read();
        set_fields(0, 1'b0, 7'h21, 8'h99);
        req = 4'b0001;
        serve(1'b1, 4, 8'h3C, 1'b1, 1'b0);
        req = '0;
        n_cmp++; if (cap_g !== 4'b0001 || cap_d !== 4'b0001 || cap_e !== 1'b0) begin n_bad++; $display("FAIL rd_grant: gnt=%b done=%b err=%b want 0001/0001/0", cap_g, cap_d, cap_e); end
        n_cmp++; if (cap_rd !== 8'h3C) begin n_bad++; $display("FAIL rd_data: rdata=%h want 3c", cap_rd); end
        n_cmp++; if (cap_w !== 1'b0 || cap_w2 !== 1'b0 || cap_a !== 7'h21) begin n_bad++; $display("FAIL rd_dir: wr=%b/%b addr=%h want 0/0/21", cap_w, cap_w2, cap_a); end
        rdata_m = 8'h3C; rr_m = 1;
    endtask

    task automatic test_fairness();
        int w;
        logic [7:0] rd;
        for (int i = 0; i < N; i++) set_fields(i, 1'($urandom), 7'($urandom), 8'($urandom));
        req = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            w = pick(req);
            rd = 8'($urandom);
            serve(1'b1, 10, rd, 1'b1, 1'b0);
            n_cmp++; if (!srv_ok || cap_g !== 4'(1 << w) || cap_d !== 4'(1 << w)) begin n_bad++; $display("FAIL fair_order[%0d]: gnt=%b done=%b want %b", k, cap_g, cap_d, 4'(1 << w)); end
            if (!req_wr[w]) rdata_m = rd;
            rr_m = (w + 1) % N;
        end
        req = '0;
        n_cmp++; if (cap_rd !== rdata_m) begin n_bad++; $display("FAIL fair_rdata: rdata=%h want %h", cap_rd, rdata_m); end
    endtask

    task automatic test_timeout();
        int w;
        req = 4'b0110;
        w = pick(req);
        serve(1'b1, 0, 8'h00, 1'b0, 1'b0);
        req[w] = 1'b0;
        n_cmp++; if (cap_d !== 4'(1 << w) || cap_e !== 1'b1 || lat != T) begin n_bad++; $display("FAIL to_abort: done=%b err=%b lat=%0d want %b/1/%0d", cap_d, cap_e, lat, 4'(1 << w), T); end
        n_cmp++; if (cap_rd !== rdata_m) begin n_bad++; $display("FAIL to_rdata_kept: rdata=%h want %h", cap_rd, rdata_m); end
        rr_m = (w + 1) % N;
        w = pick(req);
        serve(1'b1, 2, 8'h5A, 1'b1, 1'b0);
        req = '0;
        n_cmp++; if (cap_g !== 4'(1 << w) || cap_e !== 1'b0 || lat != 1) begin n_bad++; $display("FAIL to_next: gnt=%b err=%b lat=%0d want %b/0/1", cap_g, cap_e, lat, 4'(1 << w)); end
        if (!req_wr[w]) rdata_m = 8'h5A;
        rr_m = (w + 1) % N;
    endtask

    task automatic test_stale_done();
        bit early = 1'b0;
        int n;
        set_fields(3, 1'b0, 7'h0F, 8'h00);
        m_done = 1'b1; m_rdata = 8'hC3;
        req = 4'b1000;
        for (int i = 0; i < 10 && m_newd !== 1'b1; i++) @(negedge clk);
        repeat (5) begin @(negedge clk); if (rsp_done != '0) early = 1'b1; end
        n_cmp++; if (early) begin n_bad++; $display("FAIL stale_no_done: rsp_done seen=1 want 0"); end
        m_done = 1'b0;
        @(negedge clk);
        m_done = 1'b1;
        n = 0;
        while (rsp_done == '0 && n < 40) begin @(negedge clk); n++; end
        n_cmp++; if (rsp_done !== 4'b1000 || n != 1 || rsp_rdata !== 8'hC3) begin n_bad++; $display("FAIL stale_fresh_edge: done=%b lat=%0d rdata=%h want 1000/1/c3", rsp_done, n, rsp_rdata); end
        @(negedge clk);
        m_done = 1'b0; req = '0;
        rdata_m = 8'hC3; rr_m = 0;
    endtask

    task automatic test_drop_before_grant();
        bit stray = 1'b0;
        int n0;
        set_fields(2, 1'b1, 7'h11, 8'h22);
        set_fields(0, 1'b1, 7'h33, 8'h44);
        req = 4'b0100;
        @(negedge clk);
        req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        serve(1'b0, 0, 8'h00, 1'b1, 1'b0);
        req = '0;
        n_cmp++; if (cap_g !== 4'b0100 || cap_a !== 7'h11) begin n_bad++; $display("FAIL drop_owner: gnt=%b addr=%h want 0100/11", cap_g, cap_a); end
        n0 = newd_cnt;
        repeat (6) begin @(negedge clk); if (gnt != '0) stray = 1'b1; end
        n_cmp++; if (stray || newd_cnt != n0) begin n_bad++; $display("FAIL drop_never_served: stray=%b newd=%0d want 0/0", stray, newd_cnt - n0); end
        rr_m = 3;
    endtask

    task automatic test_random();
        int w;
        bit to, scr;
        logic ew;
        logic [6:0] ea;
        logic [7:0] ed, rd;
        for (int i = 0; i < N; i++) set_fields(i, 1'($urandom), 7'($urandom), 8'($urandom));
        req = 4'($urandom_range(1, 15));
        for (int k = 0; k < 24; k++) begin
            w = pick(req);
            ew = req_wr[w]; ea = req_addr[7*w +: 7]; ed = req_wdata[8*w +: 8];
            to = ($urandom_range(0, 5) == 0);
            scr = 1'($urandom);
            rd = 8'($urandom);
            serve(1'b1, to ? 0 : $urandom_range(0, 8), rd, !to, scr);
            n_cmp++; if (!srv_ok || cap_g !== 4'(1 << w) || cap_d !== 4'(1 << w) || cap_e !== to) begin n_bad++; $display("FAIL rnd_txn[%0d]: gnt=%b done=%b err=%b want %b/%b/%b", k, cap_g, cap_d, cap_e, 4'(1 << w), 4'(1 << w), to); end
            n_cmp++; if ({cap_w, cap_a, cap_wd, cap_w2, cap_a2} !== {ew, ea, ed, ew, ea}) begin n_bad++; $display("FAIL rnd_fields[%0d]: wr=%b addr=%h wdata=%h late wr=%b addr=%h want %b/%h/%h", k, cap_w, cap_a, cap_wd, cap_w2, cap_a2, ew, ea, ed); end
            if (!to && !ew) rdata_m = rd;
            n_cmp++; if (cap_rd !== rdata_m || lat != (to ? T : 1)) begin n_bad++; $display("FAIL rnd_resp[%0d]: rdata=%h lat=%0d want %h/%0d", k, cap_rd, lat, rdata_m, to ? T : 1); end
            rr_m = (w + 1) % N;
            req[w] = 1'b0;
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    set_fields(i, 1'($urandom), 7'($urandom), 8'($urandom));
                    req[i] = 1'b1;
                end
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        set_fields(1, 1'b1, 7'h41, 8'h42);
        req = 4'b0010;
        serve(1'b1, 1, 8'h00, 1'b1, 1'b0);
        req = '0;
        rr_m = 2;
        set_fields(3, 1'b0, 7'h7E, 8'h7F);
        req = 4'b1000;
        for (int i = 0; i < 10 && m_newd !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (gnt !== '0 || m_newd !== 1'b0 || rsp_done !== '0 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL rstw_ctrl: gnt=%b newd=%b done=%b err=%b want 0", gnt, m_newd, rsp_done, rsp_err); end
        n_cmp++; if ({m_wr, m_addr, m_wdata, rsp_rdata} !== {1'b1, 23'h0}) begin n_bad++; $display("FAIL rstw_data: wr=%b addr=%h wdata=%h rdata=%h want 1/0/0/0", m_wr, m_addr, m_wdata, rsp_rdata); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rr_m = 0; rdata_m = 8'h00;
        req = 4'b1010;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'(1 << pick(req))) begin n_bad++; $display("FAIL rstw_regrant: gnt=%b want %b", gnt, 4'(1 << pick(req))); end
        serve(1'b1, 2, 8'h00, 1'b1, 1'b0);
        req = '0;
        n_cmp++; if (cap_d !== 4'b0010 || cap_a !== 7'h41) begin n_bad++; $display("FAIL rstw_complete: done=%b addr=%h want 0010/41", cap_d, cap_a); end
        rr_m = 2;
    endtask

    task automatic test_invariants();
        repeat (2) @(negedge clk);
        n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL invariants: violations=%0d want 0", viol); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fairness();
        test_timeout();
        test_stale_done();
        test_drop_before_grant();
        test_random();
        test_reset_in_wait();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
